clk_div_prog: RTL

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_duty.sv | 32 +++
 rtl/clk_div_prog.sv | 119 +++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Smallest ratio that still yields a distinct high and low phase.
  localparam int unsigned DIV_MIN = 2;

  // Ratios below DIV_MIN are treated as DIV_MIN; everything else passes through.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'(DIV_MIN)) ? 32'(DIV_MIN) : d;
  endfunction

endpackage

// File: rtl/clk_div_duty.sv
// Duty-cycle shaper: rising-edge flag, falling-edge copy and the parity mux
// that stretches odd ratios by half a CLK cycle.
module clk_div_duty
  import clk_div_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic pos_next,
  input  logic odd,
  output logic CLK_OUT
);

  logic pos_q;
  logic neg_q;

  // Registered high-phase flag, taken from next-state so it never glitches.
  always_ff @(posedge CLK) begin
    if (RST) pos_q <= 1'b0;
    else     pos_q <= pos_next;
  end

  // Half-cycle delayed copy of the high-phase flag for odd-ratio stretching.
  always_ff @(negedge CLK) begin
    if (RST) neg_q <= 1'b0;
    else     neg_q <= pos_q;
  end

  // Both flags are low in the last phase of every period, so a parity change
  // at a period boundary cannot produce a glitch here.
  assign CLK_OUT = pos_q | (odd & neg_q);

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider: run/idle FSM, phase counter and divisor shadow.
// Starts, stops and divisor changes only land on period boundaries.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 40
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [DIV_W-1:0] DIV,
  input  logic             LOAD,
  output logic             CLK_OUT,
  output logic             TICK,
  output logic [DIV_W-1:0] DIV_ACT,
  output logic             RUNNING
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] ph_q, ph_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             tick_q, tick_d;
  logic [DIV_W-1:0] div_clamped;
  logic [DIV_W-1:0] d_last;
  logic             boundary;
  logic             pos_next;

  assign div_clamped = DIV_W'(clamp_div(32'(DIV)));
  assign d_last      = div_act_q - DIV_W'(1);
  assign boundary    = (state_q == ST_RUN) && (ph_q == d_last);

  // Next state and phase: a stop request only takes effect at a boundary.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    case (state_q)
      ST_IDLE: begin
        ph_d = '0;
        if (EN) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (boundary) begin
          ph_d = '0;
          if (!EN) state_d = ST_IDLE;
        end else begin
          ph_d = ph_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ph_d    = '0;
      end
    endcase
  end

  // Divisor shadow: last LOAD wins; applied immediately in IDLE, at the boundary in RUN.
  always_comb begin
    div_act_d  = div_act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (boundary && LOAD) begin
      div_act_d  = div_clamped;
      pend_vld_d = 1'b0;
    end else begin
      if (pend_vld_q && ((state_q == ST_IDLE) || boundary)) begin
        div_act_d  = pend_q;
        pend_vld_d = 1'b0;
      end
      if (LOAD) begin
        pend_d     = div_clamped;
        pend_vld_d = 1'b1;
      end
    end
  end

  // Outputs derived from next-state so they line up with the new phase.
  always_comb begin
    pos_next = (state_d == ST_RUN) && (ph_d < (div_act_d >> 1));
    tick_d   = (state_d == ST_RUN) && (ph_d == '0);
  end

  // Control state: FSM, phase counter, active divisor and tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      ph_q       <= '0;
      div_act_q  <= DIV_W'(DIV_DEFAULT);
      pend_vld_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      div_act_q  <= div_act_d;
      pend_vld_q <= pend_vld_d;
      tick_q     <= tick_d;
    end
  end

  // Pending divisor value; only meaningful while its valid flag is set.
  always_ff @(posedge CLK) begin
    pend_q <= pend_d;
  end

  clk_div_duty u_duty (
    .CLK      (CLK),
    .RST      (RST),
    .pos_next (pos_next),
    .odd      (div_act_q[0]),
    .CLK_OUT  (CLK_OUT)
  );

  assign TICK    = tick_q;
  assign DIV_ACT = div_act_q;
  assign RUNNING = (state_q == ST_RUN);

endmodule
